audio_clk_nco: RTL and testbench

//  Multi-channel programmable audio clock generator; successor to the fixed single-output audio PLL wrapper.

---
 rtl/audio_clk_nco.sv | 152 +++++++++++++++
 tb/tb_audio_clk_nco.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_clk_nco.sv
`default_nettype none
// ============================================================================
// audio_clk_nco : NUM_CLKS phase-accumulator audio clocks with a valid/ready
// config port and a settle-based lock flag. Define AUDIO_NCO_SYNC_EN to add
// the sync_req input that realigns every channel to its stored phase.
// Revision: 1.0
// ============================================================================
module audio_clk_nco #(
   parameter int NUM_CLKS    = 3,
   parameter int ACC_W       = 32,
   parameter int SEL_W       = 4,
   parameter int LOCK_CYCLES = 1024
) (
   input  logic                refclk,
   input  logic                rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [SEL_W-1:0]    cfg_sel,
   input  logic [ACC_W-1:0]    cfg_inc,
   input  logic [ACC_W-1:0]    cfg_phase,
   output logic [NUM_CLKS-1:0] outclk,
   output logic [NUM_CLKS-1:0] outclk_en,
   output logic                locked
`ifdef AUDIO_NCO_SYNC_EN
   ,
   input  logic                sync_req
`endif
);

   localparam int               CNT_W      = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(LOCK_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SETTLE = 2'd2,
      LOCKED = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ready_q, ready_d;
   logic                locked_q, locked_d;
   logic [NUM_CLKS-1:0] outclk_q, outclk_d;
   logic [NUM_CLKS-1:0] en_q, en_d;
   logic [ACC_W-1:0]    acc_q [NUM_CLKS];
   logic [ACC_W-1:0]    acc_d [NUM_CLKS];
   logic [ACC_W-1:0]    inc_q [NUM_CLKS];
   logic [ACC_W-1:0]    inc_d [NUM_CLKS];
`ifdef AUDIO_NCO_SYNC_EN
   logic [ACC_W-1:0]    phase_q [NUM_CLKS];
   logic [ACC_W-1:0]    phase_d [NUM_CLKS];
`endif
   logic                accept;
   logic                sel_ok;

   always_comb begin
      accept = cfg_valid & ready_q;
      sel_ok = int'(cfg_sel) < NUM_CLKS;

      for (int i = 0; i < NUM_CLKS; i++) begin
         acc_d[i]    = acc_q[i] + inc_q[i];
         inc_d[i]    = inc_q[i];
         outclk_d[i] = acc_q[i][ACC_W-1];
         en_d[i]     = acc_q[i][ACC_W-1] & ~outclk_q[i];
`ifdef AUDIO_NCO_SYNC_EN
         phase_d[i]  = phase_q[i];
         if (sync_req) begin
            acc_d[i] = phase_q[i];
            en_d[i]  = 1'b0;
         end
`endif
         // A config write overrides the sync reload for its own channel.
         if (accept && sel_ok && (int'(cfg_sel) == i)) begin
            acc_d[i] = cfg_phase;
            inc_d[i] = cfg_inc;
`ifdef AUDIO_NCO_SYNC_EN
            phase_d[i] = cfg_phase;
`endif
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ready_d  = ready_q;
      locked_d = locked_q;
      if (accept && sel_ok) begin
         state_d  = LOAD;
         locked_d = 1'b0;
         ready_d  = 1'b0;
      end else begin
         case (state_q)
            LOAD: begin
               cnt_d   = C_CNT_LOAD;
               ready_d = 1'b1;
               state_d = SETTLE;
            end
            SETTLE: begin
               if (cnt_q == '0) begin
                  locked_d = 1'b1;
                  state_d  = LOCKED;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
         locked_q <= 1'b0;
         outclk_q <= '0;
         en_q     <= '0;
         for (int i = 0; i < NUM_CLKS; i++) begin
            acc_q[i] <= '0;
            inc_q[i] <= '0;
`ifdef AUDIO_NCO_SYNC_EN
            phase_q[i] <= '0;
`endif
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         locked_q <= locked_d;
         outclk_q <= outclk_d;
         en_q     <= en_d;
         for (int i = 0; i < NUM_CLKS; i++) begin
            acc_q[i] <= acc_d[i];
            inc_q[i] <= inc_d[i];
`ifdef AUDIO_NCO_SYNC_EN
            phase_q[i] <= phase_d[i];
`endif
         end
      end
   end

   assign cfg_ready = ready_q;
   assign locked    = locked_q;
   assign outclk    = outclk_q;
   assign outclk_en = en_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_clk_nco.sv
`default_nettype none
// ============================================================================
// tb_audio_clk_nco : scoreboard bench for audio_clk_nco (3 channels, 32-bit,
// LOCK_CYCLES=16). Define AUDIO_NCO_SYNC_EN to also exercise sync_req.
// Revision: 1.0
// ============================================================================
module tb_audio_clk_nco;

   localparam int NCH = 3;
   localparam int LC  = 16;

   logic        clk;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [3:0]  cfg_sel;
   logic [31:0] cfg_inc;
   logic [31:0] cfg_phase;
   logic [2:0]  outclk;
   logic [2:0]  outclk_en;
   logic        locked;
`ifdef AUDIO_NCO_SYNC_EN
   logic        sync_req;
`endif

   audio_clk_nco #(
      .NUM_CLKS   (NCH),
      .ACC_W      (32),
      .SEL_W      (4),
      .LOCK_CYCLES(LC)
   ) dut (
      .refclk   (clk),
      .rst      (rst),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_sel  (cfg_sel),
      .cfg_inc  (cfg_inc),
      .cfg_phase(cfg_phase),
      .outclk   (outclk),
      .outclk_en(outclk_en),
      .locked   (locked)
`ifdef AUDIO_NCO_SYNC_EN
      ,
      .sync_req (sync_req)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [2:0] oc;
      logic [2:0] en;
      logic       lk;
      logic       rd;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   // Behavioural reference state
   logic [31:0] m_acc [NCH];
   logic [31:0] m_inc [NCH];
   logic [31:0] m_ph  [NCH];
   logic [2:0]  m_out;
   logic [2:0]  m_en;
   logic        m_ready;
   int          edge_n;
   int          lock_edge;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_acc[i] = '0;
         m_inc[i] = '0;
         m_ph[i]  = '0;
      end
      m_out     = '0;
      m_en      = '0;
      m_ready   = 1'b1;
      edge_n    = 0;
      lock_edge = -1;
   endtask

   // Advance the reference by one edge using the currently driven inputs.
   task automatic model_edge();
      logic [31:0] nacc [NCH];
      logic        acc_ok;
      exp_t        e;
      edge_n++;
      acc_ok = cfg_valid && m_ready;
      for (int i = 0; i < NCH; i++) begin
         m_en[i]  = m_acc[i][31] & ~m_out[i];
         m_out[i] = m_acc[i][31];
         nacc[i]  = m_acc[i] + m_inc[i];
      end
`ifdef AUDIO_NCO_SYNC_EN
      if (sync_req) begin
         for (int i = 0; i < NCH; i++) nacc[i] = m_ph[i];
         m_en = '0;
      end
`endif
      if (acc_ok && cfg_sel < 4'(NCH)) begin
         nacc[cfg_sel]  = cfg_phase;
         m_inc[cfg_sel] = cfg_inc;
         m_ph[cfg_sel]  = cfg_phase;
         lock_edge      = edge_n + 1 + LC;
         m_ready        = 1'b0;
      end else begin
         m_ready = 1'b1;
      end
      for (int i = 0; i < NCH; i++) m_acc[i] = nacc[i];
      e.oc = m_out;
      e.en = m_en;
      e.lk = (lock_edge >= 0) && (edge_n >= lock_edge);
      e.rd = m_ready;
      exp_q.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      model_edge();
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("outclk",    32'(outclk),    32'(e.oc));
      check("outclk_en", 32'(outclk_en), 32'(e.en));
      check("locked",    32'(locked),    32'(e.lk));
      check("cfg_ready", 32'(cfg_ready), 32'(e.rd));
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic write_cfg(input logic [3:0] sel, input logic [31:0] inc, input logic [31:0] ph);
      cfg_valid = 1'b1;
      cfg_sel   = sel;
      cfg_inc   = inc;
      cfg_phase = ph;
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_outclk"},    32'(outclk),    32'd0);
      check({tag, "_outclk_en"}, 32'(outclk_en), 32'd0);
      check({tag, "_locked"},    32'(locked),    32'd0);
      check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      cfg_valid = 1'b0;
      cfg_sel   = '0;
      cfg_inc   = '0;
      cfg_phase = '0;
`ifdef AUDIO_NCO_SYNC_EN
      sync_req  = 1'b0;
`endif
      model_reset();
      #12;
      check_reset_outputs("rst_init");
      #1 rst = 1'b0;
      run(3);

      // ch0 quarter-rate clock, then ch1 written mid-settle
      write_cfg(4'd0, 32'h4000_0000, 32'h0);
      run(6);
      write_cfg(4'd1, 32'h2000_0000, 32'h0);
      run(LC + 6);

      // out-of-range channel while locked, valid held for several cycles
      cfg_valid = 1'b1;
      cfg_sel   = 4'd3;
      cfg_inc   = 32'hDEAD_BEEF;
      cfg_phase = 32'h1234_5678;
      run(4);
      cfg_sel = 4'd15;
      run(2);
      cfg_valid = 1'b0;
      run(4);

      // ch2 wrap with large increment, then back-to-back writes with valid held
      write_cfg(4'd2, 32'hC000_0000, 32'h1234_5678);
      run(5);
      cfg_valid = 1'b1;
      cfg_sel   = 4'd2;
      cfg_inc   = 32'h0;
      cfg_phase = 32'h9000_0000;
      run(5);
      cfg_valid = 1'b0;
      run(LC + 4);

`ifdef AUDIO_NCO_SYNC_EN
      write_cfg(4'd1, 32'h4000_0000, 32'h8000_0000);
      run(2);
      write_cfg(4'd0, 32'h4000_0000, 32'h0);
      run(5);
      sync_req = 1'b1;
      step();
      sync_req = 1'b0;
      run(12);
      // sync concurrent with a write to ch2
      sync_req  = 1'b1;
      cfg_valid = 1'b1;
      cfg_sel   = 4'd2;
      cfg_inc   = 32'h2000_0000;
      cfg_phase = 32'h4000_0000;
      step();
      sync_req  = 1'b0;
      cfg_valid = 1'b0;
      run(LC + 4);
`endif

      // asynchronous reset mid-run, between edges
      write_cfg(4'd0, 32'h6000_0000, 32'h8000_0000);
      run(3);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("rst_async");
      #1 rst = 1'b0;
      model_reset();
      run(4);
      write_cfg(4'd1, 32'h4000_0000, 32'h0);
      run(LC + 4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
